// File: rtl/dev_btn_panel.sv
// Push-button front end: sync, counter debounce, press/release pulses and a one-entry event register.
// Optional auto-repeat is built only when BTN_AUTOREPEAT_EN is defined.
module dev_btn_panel #(
  parameter int NUM_BTN          = 2,
  parameter int DEB_CYCLES       = 12000,
  parameter int ACTIVE_HIGH      = 1,
  parameter int REPEAT_DELAY_CYC = 6000000,
  parameter int REPEAT_RATE_CYC  = 1200000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_repeat,
  output logic               evt_valid,
  output logic [3:0]         evt_id,
  output logic               evt_is_rep,
  input  logic               evt_ack,
  output logic               evt_overflow
);

  localparam int                 CNT_W    = (DEB_CYCLES < 1) ? 1 : $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [NUM_BTN-1:0] POL_MASK = (ACTIVE_HIGH != 0) ? {NUM_BTN{1'b0}} : {NUM_BTN{1'b1}};

  generate
    if (DEB_CYCLES < 1 || NUM_BTN < 1 || NUM_BTN > 16 ||
        REPEAT_DELAY_CYC < 1 || REPEAT_RATE_CYC < 1) begin : g_bad_cfg
      $error("dev_btn_panel: illegal parameter set");
    end
  endgenerate

  logic [NUM_BTN-1:0] sync1_r;
  logic [NUM_BTN-1:0] sync2_r;
  logic [NUM_BTN-1:0] level_r;
  logic [NUM_BTN-1:0] press_r;
  logic [NUM_BTN-1:0] release_r;
  logic [CNT_W-1:0]   cnt_r [NUM_BTN];
  logic [NUM_BTN-1:0] accept_s;
  logic [NUM_BTN-1:0] repeat_s;

  logic               valid_r;
  logic [3:0]         id_r;
  logic               is_rep_r;
  logic               overflow_r;
  logic [NUM_BTN-1:0] evt_src_s;
  logic               cand_s;
  logic               multi_s;
  logic               press_hit_s;
  logic [3:0]         cand_id_s;
  logic               cand_rep_s;

  // Channel accepts a level change on the last cycle of a full stable run
  always_comb begin
    accept_s = {NUM_BTN{1'b0}};
    for (int i = 0; i < NUM_BTN; i++) begin
      accept_s[i] = (sync2_r[i] != level_r[i]) && (cnt_r[i] == CNT_LAST);
    end
  end

  // Synchronizer, debounce counters, level and edge pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r   <= {NUM_BTN{1'b0}};
      sync2_r   <= {NUM_BTN{1'b0}};
      level_r   <= {NUM_BTN{1'b0}};
      press_r   <= {NUM_BTN{1'b0}};
      release_r <= {NUM_BTN{1'b0}};
      for (int i = 0; i < NUM_BTN; i++) begin
        cnt_r[i] <= {CNT_W{1'b0}};
      end
    end else begin
      sync1_r <= btn_raw ^ POL_MASK;
      sync2_r <= sync1_r;
      for (int i = 0; i < NUM_BTN; i++) begin
        if (sync2_r[i] == level_r[i]) begin
          cnt_r[i]     <= {CNT_W{1'b0}};
          press_r[i]   <= 1'b0;
          release_r[i] <= 1'b0;
        end else if (accept_s[i]) begin
          level_r[i]   <= sync2_r[i];
          cnt_r[i]     <= {CNT_W{1'b0}};
          press_r[i]   <= sync2_r[i];
          release_r[i] <= ~sync2_r[i];
        end else begin
          cnt_r[i]     <= cnt_r[i] + CNT_W'(1);
          press_r[i]   <= 1'b0;
          release_r[i] <= 1'b0;
        end
      end
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ? REPEAT_DELAY_CYC : REPEAT_RATE_CYC;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  logic [REP_W-1:0]   rep_cnt_r [NUM_BTN];
  logic [NUM_BTN-1:0] repeat_r;

  // Repeat timer: armed by the press pulse, silent while released or releasing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      repeat_r <= {NUM_BTN{1'b0}};
      for (int i = 0; i < NUM_BTN; i++) begin
        rep_cnt_r[i] <= {REP_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if (accept_s[i] && sync2_r[i]) begin
          rep_cnt_r[i] <= REP_W'(REPEAT_DELAY_CYC - 1);
          repeat_r[i]  <= 1'b0;
        end else if (!level_r[i] || accept_s[i]) begin
          rep_cnt_r[i] <= {REP_W{1'b0}};
          repeat_r[i]  <= 1'b0;
        end else if (rep_cnt_r[i] == {REP_W{1'b0}}) begin
          rep_cnt_r[i] <= REP_W'(REPEAT_RATE_CYC - 1);
          repeat_r[i]  <= 1'b1;
        end else begin
          rep_cnt_r[i] <= rep_cnt_r[i] - REP_W'(1);
          repeat_r[i]  <= 1'b0;
        end
      end
    end
  end

  assign repeat_s = repeat_r;
`else
  assign repeat_s = {NUM_BTN{1'b0}};
`endif

  // Event candidate: any press outranks any repeat, then lowest index wins
  always_comb begin
    evt_src_s   = press_r | repeat_s;
    cand_s      = |evt_src_s;
    multi_s     = (evt_src_s & (evt_src_s - NUM_BTN'(1))) != {NUM_BTN{1'b0}};
    press_hit_s = |press_r;
    cand_id_s   = 4'd0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (press_hit_s ? press_r[i] : repeat_s[i]) begin
        cand_id_s = 4'(i);
      end else begin
        cand_id_s = cand_id_s;
      end
    end
    cand_rep_s = cand_s & ~press_hit_s;
  end

  // One-entry event register; a pop and a new event in the same cycle keep it full
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r    <= 1'b0;
      id_r       <= 4'd0;
      is_rep_r   <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      if (cand_s && (!valid_r || evt_ack)) begin
        valid_r  <= 1'b1;
        id_r     <= cand_id_s;
        is_rep_r <= cand_rep_s;
      end else if (valid_r && evt_ack) begin
        valid_r  <= 1'b0;
      end else begin
        valid_r  <= valid_r;
      end
      if (multi_s || (cand_s && valid_r && !evt_ack)) begin
        overflow_r <= 1'b1;
      end else if (valid_r && evt_ack) begin
        overflow_r <= 1'b0;
      end else begin
        overflow_r <= overflow_r;
      end
    end
  end

  assign btn_level    = level_r;
  assign btn_press    = press_r;
  assign btn_release  = release_r;
  assign btn_repeat   = repeat_s;
  assign evt_valid    = valid_r;
  assign evt_id       = id_r;
  assign evt_is_rep   = is_rep_r;
  assign evt_overflow = overflow_r;

endmodule

// File: tb/tb_dev_btn_panel.sv
// Self-checking bench for dev_btn_panel: directed scenarios plus random pin activity,
// checked every cycle against a run-length/event-list reference model (two polarities).
module tb_dev_btn_panel;
  localparam int NB   = 2;
  localparam int DEB  = 4;
  localparam int DLY  = 10;
  localparam int RATE = 3;
`ifdef BTN_AUTOREPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NB-1:0] raw = '0;
  logic [NB-1:0] raw_n;
  logic ack = 1'b0;

  logic [NB-1:0] lvl, prs, rel, rep, n_lvl, n_prs, n_rel, n_rep;
  logic vld, isr, ovf, n_vld, n_isr, n_ovf;
  logic [3:0] eid, n_eid;

  assign raw_n = ~raw;
  always #5 clk = ~clk;

  dev_btn_panel #(.NUM_BTN(NB), .DEB_CYCLES(DEB), .ACTIVE_HIGH(1),
                  .REPEAT_DELAY_CYC(DLY), .REPEAT_RATE_CYC(RATE)) dut (
    .clk(clk), .rst_n(rst_n), .btn_raw(raw), .btn_level(lvl), .btn_press(prs),
    .btn_release(rel), .btn_repeat(rep), .evt_valid(vld), .evt_id(eid),
    .evt_is_rep(isr), .evt_ack(ack), .evt_overflow(ovf));

  dev_btn_panel #(.NUM_BTN(NB), .DEB_CYCLES(DEB), .ACTIVE_HIGH(0),
                  .REPEAT_DELAY_CYC(DLY), .REPEAT_RATE_CYC(RATE)) dut_n (
    .clk(clk), .rst_n(rst_n), .btn_raw(raw_n), .btn_level(n_lvl), .btn_press(n_prs),
    .btn_release(n_rel), .btn_repeat(n_rep), .evt_valid(n_vld), .evt_id(n_eid),
    .evt_is_rep(n_isr), .evt_ack(ack), .evt_overflow(n_ovf));

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t0;

  // reference model state
  logic [NB-1:0] m_d1, m_d2, m_lvl, m_press, m_rel, m_rep;
  int m_run [NB];
  int m_since [NB];
  logic m_valid, m_isrep, m_ovf;
  logic [3:0] m_id;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_d1 = '0; m_d2 = '0; m_lvl = '0; m_press = '0; m_rel = '0; m_rep = '0;
    m_valid = 1'b0; m_isrep = 1'b0; m_ovf = 1'b0; m_id = 4'd0;
    for (int i = 0; i < NB; i++) begin
      m_run[i] = 0;
      m_since[i] = 0;
    end
  endtask

  // One clock edge of the reference model, using pre-edge inputs and pulses
  task automatic model_edge();
    logic [NB-1:0] ev;
    logic old_valid, popped, acc;
    int pick;
    ev = m_press | m_rep;
    old_valid = m_valid;
    popped = old_valid && ack;
    pick = -1;
    for (int i = NB - 1; i >= 0; i--) if (m_press[i]) pick = i;
    if (pick < 0) for (int i = NB - 1; i >= 0; i--) if (m_rep[i]) pick = i;
    if (pick >= 0) begin
      if (!old_valid || ack) begin
        m_valid = 1'b1;
        m_id = 4'(pick);
        m_isrep = (m_press == '0);
      end
    end else if (popped) begin
      m_valid = 1'b0;
    end
    if ($countones(ev) > 1 || (pick >= 0 && old_valid && !ack)) m_ovf = 1'b1;
    else if (popped) m_ovf = 1'b0;

    for (int i = 0; i < NB; i++) begin
      m_press[i] = 1'b0; m_rel[i] = 1'b0; m_rep[i] = 1'b0;
      acc = 1'b0;
      if (m_d2[i] != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          acc = 1'b1;
          m_run[i] = 0;
          m_lvl[i] = m_d2[i];
          if (m_lvl[i]) begin
            m_press[i] = 1'b1;
            m_since[i] = 0;
          end else begin
            m_rel[i] = 1'b1;
          end
        end
      end else begin
        m_run[i] = 0;
      end
      if (!acc && m_lvl[i]) begin
        m_since[i]++;
        m_rep[i] = REP_EN && m_since[i] >= DLY && ((m_since[i] - DLY) % RATE) == 0;
      end
    end
    m_d2 = m_d1;
    m_d1 = raw;
  endtask

  task automatic check_all();
    chk("level", lvl, m_lvl);       chk("n_level", n_lvl, m_lvl);
    chk("press", prs, m_press);     chk("n_press", n_prs, m_press);
    chk("release", rel, m_rel);     chk("n_release", n_rel, m_rel);
    chk("repeat", rep, m_rep);      chk("n_repeat", n_rep, m_rep);
    chk("evt_valid", vld, m_valid); chk("n_evt_valid", n_vld, m_valid);
    chk("evt_id", eid, m_id);       chk("n_evt_id", n_eid, m_id);
    chk("evt_is_rep", isr, m_isrep); chk("n_evt_is_rep", n_isr, m_isrep);
    chk("evt_overflow", ovf, m_ovf); chk("n_evt_overflow", n_ovf, m_ovf);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    cyc++;
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic wait_press(input int ch);
    for (int k = 0; k < 20 && !prs[ch]; k++) tick();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic ack_one();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  initial begin
    model_reset();
    idle(3);
    rst_n = 1'b1;
    idle(2);

    // S1: press latency and first event
    raw = 2'b01;
    t0 = cyc + 1;
    wait_press(0);
    chk("s1_latency", cyc - t0, 5);
    tick();
    chk("s1_evt_valid", vld, 1);
    chk("s1_evt_id", eid, 0);
    idle(4);
    ack_one();
    raw = 2'b00;
    idle(8);
    ack_one();

    // S2: short glitch is rejected
    raw = 2'b10;
    idle(3);
    raw = 2'b00;
    idle(8);
    chk("s2_level1", lvl[1], 0);
    chk("s2_evt_valid", vld, 0);

    // S3: simultaneous presses
    raw = 2'b11;
    wait_press(0);
    tick();
    chk("s3_evt_id", eid, 0);
    chk("s3_overflow", ovf, 1);
    ack_one();
    chk("s3_pop_valid", vld, 0);
    chk("s3_pop_overflow", ovf, 0);
    raw = 2'b00;
    idle(8);
    ack_one();

    // S4: new press arriving with the ack of a held event
    raw = 2'b01;
    idle(8);
    raw = 2'b10;
    wait_press(1);
    ack_one();
    chk("s4_evt_valid", vld, 1);
    chk("s4_evt_id", eid, 1);
    chk("s4_overflow", ovf, 0);
    raw = 2'b00;
    idle(8);
    ack_one();

    // S5 / S6: long hold (repeats when built), then reset mid-count
    raw = 2'b10;
    idle(20);
    raw = 2'b11;
    idle(2);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("s6_level", lvl, 0);
    chk("s6_evt_valid", vld, 0);
    check_all();
    @(negedge clk);
    idle(2);
    rst_n = 1'b1;
    t0 = cyc + 1;
    wait_press(0);
    chk("s6_latency", cyc - t0, 5);
    ack_one();

    // Random pin activity and consumer acks
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 5) == 0) raw[$urandom_range(0, NB - 1)] ^= 1'b1;
      ack = ($urandom_range(0, 3) == 0);
      tick();
    end
    ack = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
